// File: rtl/gate_reduce_pipe_pkg.sv
// Shared definitions for gate_reduce_pipe: op encodings, identity element,
// inversion and reserved-op helpers, and tree-depth/level-width functions.
package gate_reduce_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } gate_op_e;

  // Padding value that leaves a reduction unchanged.
  function automatic logic identity(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic logic is_and_class(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic logic is_xor_class(input logic [2:0] op);
    return (op == OP_XOR) || (op == OP_XNOR);
  endfunction

  function automatic logic inverts(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Number of tree levels: smallest L >= 1 with fanin**L >= width.
  function automatic int clog(input int width, input int fanin);
    int span;
    int lv;
    span = fanin;
    lv   = 1;
    for (int i = 0; i < 8; i++) begin
      if (span < width) begin
        span = span * fanin;
        lv   = lv + 1;
      end
    end
    return lv;
  endfunction

  // Vector width entering tree level k.
  function automatic int level_width(input int width, input int fanin, input int k);
    int w;
    w = width;
    for (int i = 0; i < k; i++) begin
      w = (w + fanin - 1) / fanin;
    end
    return w;
  endfunction

endpackage

// File: rtl/gate_reduce_stage.sv
// One registered level of the reduction tree. Groups of FANIN input bits are
// reduced (missing bits padded with the op's identity) and captured together
// with op and a valid bit. The last level also applies the output inversion
// and forces reserved ops to a 0 result.
module gate_reduce_stage
  import gate_reduce_pipe_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int FANIN = 4,
  parameter bit LAST  = 1'b0,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [2:0]       op_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic [2:0]       op_out
);

  logic [OUT_W*FANIN-1:0] padded;
  logic [FANIN-1:0]       grp;
  logic [OUT_W-1:0]       red;
  logic [OUT_W-1:0]       data_nxt;
  logic                   load;

  logic [OUT_W-1:0] data_d, data_q;
  logic [2:0]       op_d, op_q;
  logic             valid_d, valid_q;

  // Tree-node reduction of the incoming vector.
  always_comb begin
    padded = {(OUT_W*FANIN){identity(op_in)}};
    padded[IN_W-1:0] = din;
    grp = '0;
    red = '0;
    for (int g = 0; g < OUT_W; g++) begin
      grp = padded[g*FANIN +: FANIN];
      if (is_and_class(op_in))      red[g] = &grp;
      else if (is_xor_class(op_in)) red[g] = ^grp;
      else                          red[g] = |grp;
    end
    data_nxt = red;
    if (LAST) begin
      data_nxt[0] = is_reserved(op_in) ? 1'b0 : (inverts(op_in) ? ~red[0] : red[0]);
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Load on accept, otherwise empty when the downstream takes the item.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_nxt;
      op_d    = op_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_AND;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = data_q;
  assign op_out    = op_q;

endmodule

// File: rtl/gate_reduce_pipe.sv
// Pipelined N-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR) with
// valid/ready on both sides. One registered stage per tree level; ready is
// combinational back through the chain so bubbles collapse without a skid.
// Optional: define GATE_REDUCE_CNT_EN to add the saturating true_cnt output
// counting delivered results with z0=1 and err=0.
module gate_reduce_pipe
  import gate_reduce_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             z0,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GATE_REDUCE_CNT_EN
  ,
  output logic [15:0]      true_cnt
`endif
);

  localparam int LEVELS = clog(WIDTH, FANIN);

  logic [LEVELS:0][WIDTH-1:0] d_bus;
  logic [LEVELS:0][2:0]       op_bus;
  logic [LEVELS:0]            v_bus;
  logic [LEVELS:0]            r_bus;
  logic                       unused_bits;

  assign d_bus[0]      = x;
  assign op_bus[0]     = op;
  assign v_bus[0]      = in_valid;
  assign in_ready      = r_bus[0];
  assign r_bus[LEVELS] = out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW = level_width(WIDTH, FANIN, k);
    localparam int OW = level_width(WIDTH, FANIN, k + 1);
    logic [OW-1:0] dout;

    gate_reduce_stage #(
      .IN_W  (IW),
      .FANIN (FANIN),
      .LAST  (k == LEVELS - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_bus[k]),
      .in_ready  (r_bus[k]),
      .din       (d_bus[k][IW-1:0]),
      .op_in     (op_bus[k]),
      .out_valid (v_bus[k+1]),
      .out_ready (r_bus[k+1]),
      .dout      (dout),
      .op_out    (op_bus[k+1])
    );

    assign d_bus[k+1] = WIDTH'(dout);
  end

  assign out_valid   = v_bus[LEVELS];
  assign z0          = d_bus[LEVELS][0];
  assign err         = is_reserved(op_bus[LEVELS]);
  assign unused_bits = ^d_bus;

`ifdef GATE_REDUCE_CNT_EN
  logic [15:0] true_cnt_d, true_cnt_q;

  // Count delivered true results, saturating at all-ones.
  always_comb begin
    true_cnt_d = true_cnt_q;
    if (out_valid && out_ready && z0 && !err && (true_cnt_q != 16'hFFFF)) begin
      true_cnt_d = true_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) true_cnt_q <= 16'd0;
    else     true_cnt_q <= true_cnt_d;
  end

  assign true_cnt = true_cnt_q;
`endif

endmodule
